pwm_timebase: RTL and testbench
===============================

# pwm_timebase

Parametrised multi-channel PWM timebase for the SMPS controller: one shared period counter with selectable up, down or up-down (centre-aligned) counting, and CH compare channels that each drive a PWM output. Period, compares and mode are double-buffered: new values take effect only at a period boundary, so the power stage never sees a truncated or glitched pulse. It generalises the plain up/down counters with modes, compare outputs and shadow loading. It sits between the digital compensator, which supplies the compare values, and the gate-drive/dead-time logic.

## Interface
- N, 10, counter, period and compare width
- CH, 2, number of compare/PWM channels
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_enable  in  1  count enable; low freezes all state
- i_mode  in  2  0 = up, 1 = down, 2 = up-down, 3 = treated as up
- i_period  in  N  requested period P
- i_cmp  in  CH*N  requested compares; channel k at bits [k*N +: N]
- i_load  in  1  request to transfer i_period/i_cmp/i_mode to the active registers at the next boundary
- o_count  out  N  counter value
- o_dir  out  1  1 = counting up
- o_pwm  out  CH  PWM outputs
- o_period_end  out  1  one-cycle pulse in the first cycle of each new period
- o_load_ack  out  1  one-cycle pulse in the first cycle in which newly loaded values are active

## Operation
- Active registers: P, C[k], mode. Reset loads them directly from i_period, i_cmp and i_mode.
- Effective period Pe = max(P,1). For Pe = 1, count is held at 0 in every mode.
- Up mode:
  - count runs 0..Pe-1.
  - Terminal is count == Pe-1; wraps to 0.
  - Period length is Pe cycles.
- Down mode:
  - count runs Pe-1..0.
  - Terminal is count == 0; wraps to Pe-1.
  - After reset the count starts at 0, so the first enabled cycle is already terminal.
- Up-down mode:
  - count runs 0, 1 .. Pe-1, Pe-2 .. 1, 0.
  - dir clears in the cycle count reaches Pe-1 (next value Pe-2) and sets in the cycle count leaves 0 going up.
  - Terminal is count == 0 with dir == 0; the next value is 1 with dir = 1.
  - Period length is 2*Pe-2 cycles (1 cycle when Pe = 1).
- Terminal tick = terminal condition AND i_enable. No terminal tick ever occurs while i_enable is low.
- PWM: o_pwm[k] = (count < C[k]), combinational from registered count and C[k].
  - C[k] = 0 gives constant low.
  - C[k] >= Pe gives constant high.
  - In up-down mode this produces a centre-aligned pulse.
- Shadow load:
  - i_load high in any cycle sets a pending flag.
  - At a terminal tick, if pending or i_load is high, the active registers take i_period, i_cmp and i_mode as sampled in that tick cycle, and pending clears.
  - The post-terminal count then uses the new mode and new Pe: up gives 0; down gives Pe_new-1; up-down gives 1 with dir = 1 (0 if Pe_new = 1).
  - Without a load, the same wrap rules apply with the unchanged values.
- i_load coinciding with a terminal tick is applied at that tick, not deferred.
- Repeated i_load before a boundary has no extra effect; the last sampled values win.
- Reset mid-period aborts the period and clears pending; no o_period_end or o_load_ack is generated by the reset.

## Timing
- Reset values: count = 0, dir = 1, pending = 0, o_period_end = 0, o_load_ack = 0. o_pwm[k] = (C[k] > 0) with the reset-loaded C.
- Counter updates on every clk edge with i_enable high; all state holds while i_enable is low.
- o_period_end and o_load_ack are registered. Both are high exactly in the cycle after a terminal tick; o_load_ack only if a load was applied.
- New P, C and mode are visible on o_count and o_pwm in the same cycle as o_load_ack.
- o_pwm has zero latency relative to o_count.
- No combinational path from inputs to outputs except through the active registers.

## Test plan
- Up mode, P = 5, C0 = 2, C1 = 5 after reset, enable high:
  - count 0,1,2,3,4,0,...
  - o_pwm[0] high on counts 0–1; o_pwm[1] constantly high.
  - o_period_end high when count returns to 0, every 5 cycles.
- Down mode, P = 4, C0 = 1:
  - count 0,3,2,1,0,3,...
  - o_pwm[0] high only at count 0.
  - o_period_end in each cycle showing 3.
- Up-down mode, P = 4, C0 = 2:
  - count 0,1,2,3,2,1,0,1,...
  - o_dir low on counts 2,1,0 after the peak.
  - o_pwm[0] high on counts 0,1 (centred around the valley).
  - o_period_end every 6 cycles, in the cycles showing 1 after the valley.
- Shadow load during an up-mode period (P = 8):
  - Drive i_load with P = 3 and C0 = 1 at count 2.
  - Old P is kept until count 7; the next cycle shows count 0, o_period_end = 1 and o_load_ack = 1.
  - Then count 0,1,2,0.
- Mode switch up→down at a boundary with P = 6: the cycle after the terminal at 5 shows count 5, then counts down; i_enable low for 3 cycles mid-period freezes count and the outputs.
- Degenerate and reset cases:
  - P = 0: count stays 0 and o_period_end pulses every enabled cycle.
  - C0 = 0 gives o_pwm[0] constant low.
  - Reset asserted at count 4 with a load pending: count 0 next cycle, and no o_load_ack afterwards until a new i_load.

Source files
------------

// File: rtl/pwm_timebase_if.sv
// pwm_timebase_if: control/status bundle between the compensator (master)
// and the PWM timebase (slave).
//   i_enable      count enable
//   i_mode        0 up, 1 down, 2 up-down, 3 up
//   i_period      requested period
//   i_cmp         requested compares, channel k at [k*N +: N]
//   i_load        shadow-load request
//   o_count       counter value
//   o_dir         1 = counting up
//   o_pwm         PWM outputs, one per channel
//   o_period_end  pulse in the first cycle of each new period
//   o_load_ack    pulse in the first cycle new values are active
interface pwm_timebase_if #(
    parameter int N  = 10,
    parameter int CH = 2
);
    logic            i_enable;
    logic [1:0]      i_mode;
    logic [N-1:0]    i_period;
    logic [CH*N-1:0] i_cmp;
    logic            i_load;
    logic [N-1:0]    o_count;
    logic            o_dir;
    logic [CH-1:0]   o_pwm;
    logic            o_period_end;
    logic            o_load_ack;

    modport master (
        output i_enable, i_mode, i_period, i_cmp, i_load,
        input  o_count, o_dir, o_pwm, o_period_end, o_load_ack
    );

    modport slave (
        input  i_enable, i_mode, i_period, i_cmp, i_load,
        output o_count, o_dir, o_pwm, o_period_end, o_load_ack
    );
endinterface

// File: rtl/pwm_timebase.sv
// pwm_timebase: shared period counter (up / down / centre-aligned up-down)
// with CH compare channels. Period, compares and mode are double-buffered
// and only transferred to the active registers at a terminal tick, so a
// period is never truncated.
//   clk    clock
//   reset  synchronous, active-high; loads active registers from the bus
//   bus    pwm_timebase_if.slave (see interface header for signal list)
module pwm_timebase #(
    parameter int N  = 10,
    parameter int CH = 2
) (
    input  logic          clk,
    input  logic          reset,
    pwm_timebase_if.slave bus
);
    localparam logic [1:0]   M_DOWN = 2'd1;
    localparam logic [1:0]   M_UPDN = 2'd2;
    localparam logic [N-1:0] ONE    = N'(1);

    logic [N-1:0]          count_q, count_d;
    logic [N-1:0]          p_q, p_d;
    logic [CH-1:0][N-1:0]  c_q, c_d;
    logic [1:0]            mode_q, mode_d;
    logic                  dir_q, dir_d;
    logic                  pending_q, pending_d;
    logic                  period_end_q, period_end_d;
    logic                  load_ack_q, load_ack_d;

    logic [N-1:0] pe_m1;      // effective period minus one, active P
    logic [N-1:0] nxt_pe_m1;  // same, for the values governing the wrap
    logic [1:0]   nxt_mode;
    logic         terminal, tick, do_load;

    // max(P,1)-1; P = 0 and P = 1 both collapse to a held-at-zero counter
    function automatic logic [N-1:0] pe_minus1(input logic [N-1:0] p);
        return (p == '0) ? '0 : p - ONE;
    endfunction

    assign pe_m1   = pe_minus1(p_q);
    assign tick    = terminal & bus.i_enable;
    assign do_load = pending_q | bus.i_load;

    always_comb begin
        case (mode_q)
            M_DOWN:  terminal = (count_q == '0);
            // Pe = 1 is a one-cycle period regardless of dir
            M_UPDN:  terminal = (pe_m1 == '0) || ((count_q == '0) && !dir_q);
            default: terminal = (count_q == pe_m1);
        endcase
    end

    always_comb begin
        count_d      = count_q;
        dir_d        = dir_q;
        p_d          = p_q;
        c_d          = c_q;
        mode_d       = mode_q;
        pending_d    = pending_q | bus.i_load;
        period_end_d = tick;
        load_ack_d   = tick & do_load;
        nxt_mode     = mode_q;
        nxt_pe_m1    = pe_m1;
        if (bus.i_enable) begin
            if (terminal) begin
                if (do_load) begin
                    p_d       = bus.i_period;
                    c_d       = bus.i_cmp;
                    mode_d    = bus.i_mode;
                    pending_d = 1'b0;
                    nxt_mode  = bus.i_mode;
                    nxt_pe_m1 = pe_minus1(bus.i_period);
                end
                // first count of the new period uses the new mode and period
                case (nxt_mode)
                    M_DOWN: begin
                        count_d = nxt_pe_m1;
                        dir_d   = 1'b0;
                    end
                    M_UPDN: begin
                        count_d = (nxt_pe_m1 == '0) ? '0 : ONE;
                        dir_d   = 1'b1;
                    end
                    default: begin
                        count_d = '0;
                        dir_d   = 1'b1;
                    end
                endcase
            end else begin
                case (mode_q)
                    M_DOWN: begin
                        count_d = count_q - ONE;
                        dir_d   = 1'b0;
                    end
                    M_UPDN: begin
                        if (dir_q && (count_q == pe_m1)) begin
                            count_d = count_q - ONE;  // turn at the peak
                            dir_d   = 1'b0;
                        end else if (dir_q) begin
                            count_d = count_q + ONE;
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end
                    default: begin
                        count_d = count_q + ONE;
                        dir_d   = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            dir_q        <= 1'b1;
            p_q          <= bus.i_period;
            c_q          <= bus.i_cmp;
            mode_q       <= bus.i_mode;
            pending_q    <= 1'b0;
            period_end_q <= 1'b0;
            load_ack_q   <= 1'b0;
        end else begin
            count_q      <= count_d;
            dir_q        <= dir_d;
            p_q          <= p_d;
            c_q          <= c_d;
            mode_q       <= mode_d;
            pending_q    <= pending_d;
            period_end_q <= period_end_d;
            load_ack_q   <= load_ack_d;
        end
    end

    always_comb begin
        for (int k = 0; k < CH; k++) bus.o_pwm[k] = (count_q < c_q[k]);
    end

    assign bus.o_count      = count_q;
    assign bus.o_dir        = dir_q;
    assign bus.o_period_end = period_end_q;
    assign bus.o_load_ack   = load_ack_q;
endmodule

// File: tb/tb_pwm_timebase.sv
module tb_pwm_timebase;
    localparam int N  = 10;
    localparam int CH = 2;

    typedef struct {
        logic [N-1:0] cnt;
        logic         dir;
        logic [1:0]   pwm;
        logic         pe;
        logic         la;
        string        nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    bit done = 0;

    pwm_timebase_if #(.N(N), .CH(CH)) tbif ();

    pwm_timebase #(.N(N), .CH(CH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (tbif)
    );

    always #5 clk = ~clk;

    task automatic cfg(input logic [1:0] m, input int p, input int c0, input int c1);
        tbif.i_mode   = m;
        tbif.i_period = N'(p);
        tbif.i_cmp    = {N'(c1), N'(c0)};
    endtask

    // one clock edge; the expected post-edge state goes to the scoreboard
    task automatic step(input int cnt, input logic dir, input logic [1:0] pwm,
                        input logic pe, input logic la, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.cnt = N'(cnt); e.dir = dir; e.pwm = pwm; e.pe = pe; e.la = la; e.nm = nm;
        q.push_back(e);
    endtask

    // monitor: compares the DUT against the scoreboard on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (tbif.o_count !== e.cnt || tbif.o_dir !== e.dir || tbif.o_pwm !== e.pwm ||
                    tbif.o_period_end !== e.pe || tbif.o_load_ack !== e.la) begin
                    errors++;
                    $display("FAIL %s: got cnt=%0d dir=%b pwm=%b pe=%b la=%b, want cnt=%0d dir=%b pwm=%b pe=%b la=%b",
                             e.nm, tbif.o_count, tbif.o_dir, tbif.o_pwm, tbif.o_period_end,
                             tbif.o_load_ack, e.cnt, e.dir, e.pwm, e.pe, e.la);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int uc[10]  = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
        int dc[9]   = '{3, 2, 1, 0, 3, 2, 1, 0, 3};
        int udc[13] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0, 1};
        bit udd[13] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
        int wait_cyc;

        tbif.i_enable = 1'b1;
        tbif.i_load   = 1'b0;

        // up, P=5, C0=2, C1=5
        cfg(2'd0, 5, 2, 5);
        reset = 1'b1;
        step(0, 1, 2'b11, 0, 0, "up_reset");
        reset = 1'b0;
        for (int i = 0; i < 10; i++)
            step(uc[i], 1, {1'b1, 1'(uc[i] < 2)}, 1'(uc[i] == 0), 0, "up");

        // down, P=4, C0=1, C1=0
        cfg(2'd1, 4, 1, 0);
        reset = 1'b1;
        step(0, 1, 2'b01, 0, 0, "down_reset");
        reset = 1'b0;
        for (int i = 0; i < 9; i++)
            step(dc[i], 0, {1'b0, 1'(dc[i] < 1)}, 1'(dc[i] == 3), 0, "down");

        // up-down, P=4, C0=2, C1=4
        cfg(2'd2, 4, 2, 4);
        reset = 1'b1;
        step(0, 1, 2'b11, 0, 0, "updn_reset");
        reset = 1'b0;
        for (int i = 0; i < 13; i++)
            step(udc[i], udd[i], {1'b1, 1'(udc[i] < 2)}, 1'(i == 6 || i == 12), 0, "updn");

        // shadow load in up mode: P=8 -> P=3, C0=4 -> C0=1
        cfg(2'd0, 8, 4, 8);
        reset = 1'b1;
        step(0, 1, 2'b11, 0, 0, "shadow_reset");
        reset = 1'b0;
        step(1, 1, 2'b11, 0, 0, "shadow");
        step(2, 1, 2'b11, 0, 0, "shadow");
        cfg(2'd0, 3, 1, 8);
        tbif.i_load = 1'b1;
        step(3, 1, 2'b11, 0, 0, "shadow_req");
        tbif.i_load = 1'b0;
        step(4, 1, 2'b10, 0, 0, "shadow_old");
        step(5, 1, 2'b10, 0, 0, "shadow_old");
        step(6, 1, 2'b10, 0, 0, "shadow_old");
        step(7, 1, 2'b10, 0, 0, "shadow_old");
        step(0, 1, 2'b11, 1, 1, "shadow_ack");
        step(1, 1, 2'b10, 0, 0, "shadow_new");
        step(2, 1, 2'b10, 0, 0, "shadow_new");
        step(0, 1, 2'b11, 1, 0, "shadow_wrap");
        step(1, 1, 2'b10, 0, 0, "shadow_new");

        // mode switch up -> down, P=6, C0=3, then enable freeze
        cfg(2'd0, 6, 3, 6);
        reset = 1'b1;
        step(0, 1, 2'b11, 0, 0, "mode_reset");
        reset = 1'b0;
        step(1, 1, 2'b11, 0, 0, "mode_up");
        step(2, 1, 2'b11, 0, 0, "mode_up");
        step(3, 1, 2'b10, 0, 0, "mode_up");
        cfg(2'd1, 6, 3, 6);
        tbif.i_load = 1'b1;
        step(4, 1, 2'b10, 0, 0, "mode_up");
        tbif.i_load = 1'b0;
        step(5, 1, 2'b10, 0, 0, "mode_up_term");
        step(5, 0, 2'b10, 1, 1, "mode_switch");
        step(4, 0, 2'b10, 0, 0, "mode_down");
        tbif.i_enable = 1'b0;
        for (int i = 0; i < 3; i++) step(4, 0, 2'b10, 0, 0, "freeze");
        tbif.i_enable = 1'b1;
        step(3, 0, 2'b10, 0, 0, "mode_down");
        step(2, 0, 2'b11, 0, 0, "mode_down");
        step(1, 0, 2'b11, 0, 0, "mode_down");
        step(0, 0, 2'b11, 0, 0, "mode_down");
        step(5, 0, 2'b10, 1, 0, "mode_down_wrap");

        // P=0, C0=0, C1=1
        cfg(2'd0, 0, 0, 1);
        reset = 1'b1;
        step(0, 1, 2'b10, 0, 0, "p0_reset");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(0, 1, 2'b10, 1, 0, "p0");

        // reset with a load pending
        cfg(2'd0, 8, 2, 8);
        reset = 1'b1;
        step(0, 1, 2'b11, 0, 0, "rst_reset");
        reset = 1'b0;
        step(1, 1, 2'b11, 0, 0, "rst_run");
        cfg(2'd0, 3, 1, 8);
        tbif.i_load = 1'b1;
        step(2, 1, 2'b10, 0, 0, "rst_req");
        tbif.i_load = 1'b0;
        step(3, 1, 2'b10, 0, 0, "rst_run");
        step(4, 1, 2'b10, 0, 0, "rst_run");
        cfg(2'd0, 8, 2, 8);
        reset = 1'b1;
        step(0, 1, 2'b11, 0, 0, "rst_mid");
        reset = 1'b0;
        for (int i = 1; i < 8; i++)
            step(i, 1, {1'b1, 1'(i < 2)}, 0, 0, "rst_after");
        step(0, 1, 2'b11, 1, 0, "rst_no_ack");
        step(1, 1, 2'b11, 0, 0, "rst_after");

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
